// File: rtl/updown_counter.sv
// Up/down modulo-2^WIDTH counter with a registered wrap pulse.
//
// Ports:
//   clk_i     - clock; all state updates on the rising edge
//   rst_i     - synchronous active-low reset (clears count and wrap)
//   mode_i    - count direction, 0 = up, 1 = down, sampled every edge
//   count_o   - current count, straight from the count register
//   at_max_o  - high while count_o is all ones (decoded from the register only)
//   at_min_o  - high while count_o is zero (decoded from the register only)
//   wrap_o    - high for the one cycle after an update that wrapped around
module updown_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] count_o,
  output logic             at_max_o,
  output logic             at_min_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] CountMax = '1;
  localparam logic [WIDTH-1:0] CountMin = '0;
  localparam logic [WIDTH-1:0] CountOne = WIDTH'(1);

  logic [WIDTH-1:0] count_d, count_q;
  logic             wrap_d, wrap_q;

  // No enable: every non-reset edge moves the count by exactly one.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (mode_i) begin
      count_d = count_q - CountOne;
      wrap_d  = (count_q == CountMin);
    end else begin
      count_d = count_q + CountOne;
      wrap_d  = (count_q == CountMax);
    end
  end

  // Reset wins over counting whatever mode_i is.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_o  = count_q;
  assign wrap_o   = wrap_q;
  assign at_max_o = (count_q == CountMax);
  assign at_min_o = (count_q == CountMin);

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter (WIDTH=3). Each step drives inputs, waits
// for the rising edge, pushes the model's expectation to a scoreboard queue and
// pops/compares it 1 time unit after the edge. Extra literal checks pin the
// key values from the expected waveforms.
module tb_updown_counter;

  localparam int unsigned W = 3;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         wrap;
    logic         amax;
    logic         amin;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         mode;
  logic [W-1:0] count;
  logic         at_max;
  logic         at_min;
  logic         wrap;

  int           tests;
  int           fails;
  exp_t         sb_q[$];
  logic [W-1:0] m_cnt;
  logic         m_wrap;

  updown_counter #(
    .WIDTH(W)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .mode_i  (mode),
    .count_o (count),
    .at_max_o(at_max),
    .at_min_o(at_min),
    .wrap_o  (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge with the given inputs, scored against the reference model.
  task automatic step(input logic r, input logic md, input string tag);
    exp_t e;
    exp_t got;
    rst  = r;
    mode = md;
    @(posedge clk);
    if (!r) begin
      m_cnt  = '0;
      m_wrap = 1'b0;
    end else if (md) begin
      m_wrap = (m_cnt == 3'd0);
      m_cnt  = m_cnt - 3'd1;
    end else begin
      m_wrap = (m_cnt == 3'd7);
      m_cnt  = m_cnt + 3'd1;
    end
    e.cnt  = m_cnt;
    e.wrap = m_wrap;
    e.amax = (m_cnt == 3'd7);
    e.amin = (m_cnt == 3'd0);
    sb_q.push_back(e);
    #1;
    got = sb_q.pop_front();
    chk({tag, ".count"}, 32'(count), 32'(got.cnt));
    chk({tag, ".wrap"}, 32'(wrap), 32'(got.wrap));
    chk({tag, ".at_max"}, 32'(at_max), 32'(got.amax));
    chk({tag, ".at_min"}, 32'(at_min), 32'(got.amin));
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    m_cnt  = '0;
    m_wrap = 1'b0;
    rst    = 1'b0;
    mode   = 1'b0;

    // Reset edge then count up 1..7.
    step(1'b0, 1'b0, "reset");
    chk("reset_count_lit", 32'(count), 32'd0);
    chk("reset_min_lit", 32'(at_min), 32'd1);
    for (int i = 1; i <= 7; i++) step(1'b1, 1'b0, "up");
    chk("up_reach7_lit", 32'(count), 32'd7);
    chk("at_max_at7_lit", 32'(at_max), 32'd1);

    // Up-wrap 7 -> 0, pulse lasts one cycle.
    step(1'b1, 1'b0, "upwrap");
    chk("upwrap_count_lit", 32'(count), 32'd0);
    chk("upwrap_pulse_lit", 32'(wrap), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "up_to3");
    chk("wrap_cleared_lit", 32'(wrap), 32'd0);
    chk("at3_lit", 32'(count), 32'd3);

    // Direction change at 3: 2,1,0,7 with wrap only after 0->7.
    step(1'b1, 1'b1, "dn2");
    chk("dn_first_lit", 32'(count), 32'd2);
    step(1'b1, 1'b1, "dn1");
    step(1'b1, 1'b1, "dn0");
    chk("dn0_nowrap_lit", 32'(wrap), 32'd0);
    step(1'b1, 1'b1, "dnwrap");
    chk("dnwrap_count_lit", 32'(count), 32'd7);
    chk("dnwrap_pulse_lit", 32'(wrap), 32'd1);

    // Reset mid-count at 5 while counting down, then resume down to 7.
    step(1'b1, 1'b1, "dn6");
    step(1'b1, 1'b1, "dn5");
    chk("at5_lit", 32'(count), 32'd5);
    step(1'b0, 1'b1, "midreset");
    chk("midreset_lit", 32'(count), 32'd0);
    step(1'b1, 1'b1, "resume_dn");
    chk("resume_dn_lit", 32'(count), 32'd7);
    chk("resume_dn_wrap_lit", 32'(wrap), 32'd1);

    // Reset glitch between edges must be ignored.
    #1 rst = 1'b0;
    #2 rst = 1'b1;
    step(1'b1, 1'b1, "glitch");
    chk("glitch_lit", 32'(count), 32'd6);

    // Toggle direction every edge from 4: 5,4,5,4.
    step(1'b1, 1'b1, "dn5b");
    step(1'b1, 1'b1, "dn4");
    chk("at4_lit", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i % 2) == 1, "toggle");
      chk("toggle_lit", 32'(count), (i % 2) == 1 ? 32'd4 : 32'd5);
      chk("toggle_nowrap_lit", 32'(wrap), 32'd0);
    end

    // Reset during up-count, then resume up to 1.
    step(1'b0, 1'b0, "reset_up");
    step(1'b1, 1'b0, "resume_up");
    chk("resume_up_lit", 32'(count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/updown_counter.md
UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 3, counter bit width (legal range 1..32).
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-low (rst_i=0 at a rising clk_i edge resets).
REQ-004 The block SHALL have port mode_i, input, 1 bit: count direction; 0 = up, 1 = down.
REQ-005 The block SHALL have port count_o, output, WIDTH bits: current count, driven directly from a register.
REQ-006 The block SHALL have port at_max_o, output, 1 bit: combinational flag, high when count_o == 2^WIDTH-1.
REQ-007 The block SHALL have port at_min_o, output, 1 bit: combinational flag, high when count_o == 0.
REQ-008 The block SHALL have port wrap_o, output, 1 bit: registered pulse, high for exactly the one cycle following a wrap-around update.

Function
REQ-009 The block SHALL increment count_o by 1 at each rising clk_i edge with rst_i=1 and mode_i=0.
REQ-010 The block SHALL decrement count_o by 1 at each rising clk_i edge with rst_i=1 and mode_i=1.
REQ-011 The block SHALL count with no enable: every non-reset edge changes count_o by exactly 1.
REQ-012 The block SHALL perform arithmetic modulo 2^WIDTH: up from 2^WIDTH-1 gives 0; down from 0 gives 2^WIDTH-1.
REQ-013 The block SHALL set wrap_o=1 after an edge that performs either wrap in REQ-012, and wrap_o=0 after every other edge.
REQ-014 The block SHALL sample mode_i at each edge; a mode change takes effect at the first edge where the new value is sampled, with no extra latency and no skipped or repeated value.
REQ-015 The block SHALL have one-cycle latency from an edge to the new count_o value; there is no combinational path from mode_i to count_o.
REQ-016 The block SHALL derive at_max_o and at_min_o combinationally from the count_o register only, with no dependence on mode_i.
REQ-017 The block SHALL give reset priority over counting when rst_i=0 and any mode_i value coincide at an edge.

Reset
REQ-018 The block SHALL, on an edge with rst_i=0, set count_o=0 and wrap_o=0; consequently at_min_o=1 and at_max_o=0.
REQ-019 The block SHALL make counting resume at the first edge with rst_i=1, moving to 1 (up) or 2^WIDTH-1 (down).
REQ-020 The block SHALL treat rst_i asserted mid-count identically to REQ-018, regardless of count value or direction.
REQ-021 The block SHALL not react to rst_i between clock edges (fully synchronous reset).
REQ-022 The block SHALL have count_o, wrap_o, at_max_o and at_min_o undefined until the first reset edge; no power-on value is required.

Verification (WIDTH=3, 10-unit clock period)
REQ-023 Bench SHALL hold rst_i=0 for 1 edge with mode_i=0, then set rst_i=1 -> count_o=0 during reset, then 1,2,...,7 on successive edges.
REQ-024 Bench SHALL continue counting up from 7 -> count_o=0 and wrap_o=1 for that one cycle; at_max_o=1 while count_o=7.
REQ-025 Bench SHALL switch mode_i to 1 while count_o=3 -> the following edges give 2,1,0,7; wrap_o=1 only after the 0->7 edge.
REQ-026 Bench SHALL assert rst_i=0 at count_o=5 while counting down -> count_o=0 at that edge; first edge with rst_i=1 gives 7.
REQ-027 Bench SHALL pulse rst_i=0 between clock edges and release it before the next rising edge -> count_o unaffected.
REQ-028 Bench SHALL toggle mode_i every edge starting from count_o=4 -> count_o alternates 5,4,5,4 with wrap_o=0 throughout.
